// File: rtl/truncamiento.sv
// truncamiento: registered fixed-point truncation/saturation stage.
//
// It reduces a 2N-bit signed word with 2F fractional bits to an N-bit signed
// word with F fractional bits. Values outside the N-bit range saturate to
// full scale, and overflow is raised alongside the result. The stage has one
// clock of latency and accepts one input per cycle, with no backpressure.
//
// Optional build macro TRUNCAMIENTO_ROUND_EN:
//   undefined - plain truncation (floor toward -inf); Datos_Sum[F-1] is ignored.
//   defined   - round half up: Datos_Sum[F-1] is added to the kept bits before
//               the range test, so a rounding carry can itself saturate.
//
// Legal parameters: 0 < F < N.
module truncamiento #(
  parameter int N = 25,
  parameter int F = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*N-1:0]   Datos_Sum,
  input  logic             in_valid,
  output logic [N-1:0]     Datos_Trunc,
  output logic             out_valid,
  output logic             overflow
);

  // Width of the kept part (2N-F bits) plus one guard bit. The guard bit lets
  // the optional rounding increment run without wrapping, so the range test
  // always sees the true value.
  localparam int W = 2*N - F + 1;

  // Full-scale saturation codes in N-bit two's complement.
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  logic [W-1:0] kept_ext;    // Datos_Sum[2N-1:F], sign-extended by one bit
  logic [W-1:0] inc;         // rounding increment (0 or 1)
  logic [W-1:0] sum;         // kept value after the optional rounding
  logic [W-N:0] upper;       // sum[W-1:N-1]: must be uniform to fit in N bits
  logic         in_range;
  logic [N-1:0] result;
  logic         result_ovf;

  // Choose the rounding increment for this build.
`ifdef TRUNCAMIENTO_ROUND_EN
  assign inc = {{(W-1){1'b0}}, Datos_Sum[F-1]};
`else
  assign inc = '0;
`endif

  // Compute the value to register: the slice, or full scale when it does not fit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves a signal unassigned and no latch is inferred.
    kept_ext   = {Datos_Sum[2*N-1], Datos_Sum[2*N-1:F]};
    sum        = kept_ext + inc;
    upper      = sum[W-1:N-1];
    in_range   = (&upper) | (~|upper);
    result     = sum[N-1:0];
    result_ovf = 1'b0;

    if (!in_range) begin
      // The guard bit holds the true sign because rounding never wraps W bits.
      result     = sum[W-1] ? SAT_NEG : SAT_POS;
      result_ovf = 1'b1;
    end
  end

  // Output register: a new result on accepted input; otherwise the data holds
  // and both flags drop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that existed before this clock edge.
    if (!rst_n) begin
      Datos_Trunc <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else if (in_valid) begin
      Datos_Trunc <= result;
      out_valid   <= 1'b1;
      overflow    <= result_ovf;
    end else begin
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_truncamiento.sv
// Self-checking bench for truncamiento (N=25, F=10).
// The expected values follow the build: define TRUNCAMIENTO_ROUND_EN for both
// the RTL and this bench to check the rounding build.
module tb_truncamiento;

  localparam int N = 25;
  localparam int F = 10;

  logic           clk;
  logic           clk_en;
  logic           rst_n;
  logic [2*N-1:0] Datos_Sum;
  logic           in_valid;
  logic [N-1:0]   Datos_Trunc;
  logic           out_valid;
  logic           overflow;

  int checks;
  int errors;

  truncamiento #(.N(N), .F(F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Datos_Sum   (Datos_Sum),
    .in_valid    (in_valid),
    .Datos_Trunc (Datos_Trunc),
    .out_valid   (out_valid),
    .overflow    (overflow)
  );

  // The clock is gated so that reset can be checked with no edge at all.
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk; else clk = 1'b0;

  typedef struct {
    string          name;
    logic [2*N-1:0] din;
    logic [N-1:0]   exp_q;
    logic           exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic: scale by 2^-F, round or
  // floor, then clamp to the signed N-bit range.
  function automatic void model(input logic [2*N-1:0] d, output logic [N-1:0] q,
                                output logic o);
    longint v, s, hi, lo;
    v  = longint'($signed(d));
    hi = (64'sd1 <<< (N-1)) - 1;
    lo = -(64'sd1 <<< (N-1));
`ifdef TRUNCAMIENTO_ROUND_EN
    s = (v + (64'sd1 <<< (F-1))) >>> F;
`else
    s = v >>> F;
`endif
    if (s > hi)      begin q = hi[N-1:0]; o = 1'b1; end
    else if (s < lo) begin q = lo[N-1:0]; o = 1'b1; end
    else             begin q = s[N-1:0];  o = 1'b0; end
  endfunction

  // Drive one input at the falling edge; outputs are then sampled 1 ns after
  // the following rising edge.
  task automatic apply(input logic [2*N-1:0] d, input logic v);
    @(negedge clk);
    Datos_Sum = d;
    in_valid  = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*N-1:0] rand_din();
    logic [63:0] r;
    int          w;
    r = {$urandom, $urandom};
    // Pick an effective magnitude width so that most values are in range, but
    // some lie near the range edges or far outside it.
    w = $urandom_range(2*N, 1);
    if (w < 2*N) r = (r[w-1]) ? (r | (~64'd0 << w)) : (r & ~(~64'd0 << w));
    return r[2*N-1:0];
  endfunction

  vec_t vecs[$];

  initial begin
    logic [N-1:0] eq;
    logic         eo;
    logic [N-1:0] last_q;
    bit           stream_ok;

    checks = 0;
    errors = 0;

    vecs.push_back('{"pos_3p0",   50'h0000000300000, 25'h0000C00, 1'b0});
    vecs.push_back('{"neg_1p5",   50'h3FFFFFFE80000, 25'h1FFFA00, 1'b0});
`ifdef TRUNCAMIENTO_ROUND_EN
    vecs.push_back('{"all_ones",  50'h3FFFFFFFFFFFF, 25'h0000000, 1'b0});
    vecs.push_back('{"half_600",  50'h0000000000600, 25'h0000002, 1'b0});
    vecs.push_back('{"max_half",  50'h00003FFFFFE00, 25'h0FFFFFF, 1'b1});
    vecs.push_back('{"min_m1",    50'h3FFFBFFFFFFFF, 25'h1000000, 1'b0});
`else
    vecs.push_back('{"all_ones",  50'h3FFFFFFFFFFFF, 25'h1FFFFFF, 1'b0});
    vecs.push_back('{"half_600",  50'h0000000000600, 25'h0000001, 1'b0});
    vecs.push_back('{"max_half",  50'h00003FFFFFE00, 25'h0FFFFFF, 1'b0});
    vecs.push_back('{"min_m1",    50'h3FFFBFFFFFFFF, 25'h1000000, 1'b1});
`endif
    vecs.push_back('{"below_5ff", 50'h00000000005FF, 25'h0000001, 1'b0});
    vecs.push_back('{"sat_1s40",  50'h0010000000000, 25'h0FFFFFF, 1'b1});
    vecs.push_back('{"sat_m1s45", 50'h3E00000000000, 25'h1000000, 1'b1});
    vecs.push_back('{"sat_max",   50'h1FFFFFFFFFFFF, 25'h0FFFFFF, 1'b1});
    vecs.push_back('{"exact_min", 50'h3FFFC00000000, 25'h1000000, 1'b0});

    // Reset with the clock stopped: the outputs must clear without any edge.
    clk_en    = 1'b0;
    in_valid  = 1'b1;
    Datos_Sum = {$urandom, $urandom};
    rst_n     = 1'b1;
    #3 rst_n  = 1'b0;
    #2;
    check("rst_q",   64'(Datos_Trunc), 64'd0);
    check("rst_ov",  64'(out_valid),   64'd0);
    check("rst_ovf", 64'(overflow),    64'd0);

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ov", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed vectors, one per cycle.
    foreach (vecs[i]) begin
      apply(vecs[i].din, 1'b1);
      check({vecs[i].name, "_q"},   64'(Datos_Trunc), 64'(vecs[i].exp_q));
      check({vecs[i].name, "_ovf"}, 64'(overflow),    64'(vecs[i].exp_ovf));
      check({vecs[i].name, "_ov"},  64'(out_valid),   64'd1);
    end

    // An idle cycle after a saturated result clears both flags and holds the data.
    apply(50'h0010000000000, 1'b1);
    apply(50'h0000000300000, 1'b0);
    check("idle_ov",  64'(out_valid),   64'd0);
    check("idle_ovf", 64'(overflow),    64'd0);
    check("idle_q",   64'(Datos_Trunc), 64'h0FFFFFF);

    // Reset mid-stream discards the in-flight result; the first valid edge
    // after release produces the next result.
    @(negedge clk);
    Datos_Sum = 50'h0010000000000;
    in_valid  = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("mid_rst_q",   64'(Datos_Trunc), 64'd0);
    check("mid_rst_ovf", 64'(overflow),    64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(50'h0000000300000, 1'b1);
    check("post_rst_q",  64'(Datos_Trunc), 64'h0000C00);
    check("post_rst_ov", 64'(out_valid),   64'd1);

    // Random streaming with in_valid high every cycle.
    last_q    = '0;
    stream_ok = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      logic [2*N-1:0] d;
      d = rand_din();
      model(d, eq, eo);
      apply(d, 1'b1);
      if (Datos_Trunc !== eq || overflow !== eo || out_valid !== 1'b1) begin
        if (stream_ok)
          $display("FAIL stream[%0d] din=%0h: got q=%0h ovf=%0b ov=%0b, expected q=%0h ovf=%0b ov=1",
                   i, d, Datos_Trunc, overflow, out_valid, eq, eo);
        stream_ok = 1'b0;
      end
      last_q = eq;
    end
    check("stream_all", 64'(stream_ok), 64'd1);

    apply(rand_din(), 1'b0);
    check("stream_end_ov",  64'(out_valid),   64'd0);
    check("stream_end_ovf", 64'(overflow),    64'd0);
    check("stream_end_q",   64'(Datos_Trunc), 64'(last_q));
    apply(rand_din(), 1'b0);
    check("stream_hold_q",  64'(Datos_Trunc), 64'(last_q));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/truncamiento.md
# truncamiento

Registered fixed-point truncation/saturation stage for the datapath. It reduces a double-width signed accumulator/product word of 2N bits to an N-bit signed word in the system fixed-point format. Overflow saturates to full scale and is flagged. It sits between the multiply-accumulate stage and the next filter stage, one result per accepted input.

## Interface
Parameters:
- N — 25 — output width in bits; input width is 2N.
- F — 10 — fractional bits of the N-bit format; the 2N-bit input carries 2F fractional bits. Legal range is 0 < F < N.

Ports:
- clk  input  1  — system clock; all state updates on the rising edge.
- rst_n  input  1  — reset; **one clock; reset is asynchronous and active-low**.
- Datos_Sum  input  2N  — signed two's-complement value, with 2F fractional bits.
- in_valid  input  1  — Datos_Sum is sampled on a clock edge where this is high.
- Datos_Trunc  output  N  — signed result, with F fractional bits; registered.
- out_valid  output  1  — high for one cycle per result.
- overflow  output  1  — high alongside out_valid when the result was saturated.

## Operation
- Slice: Datos_Sum[N+F-1:F], which keeps F fractional bits and discards the low F bits.
- Without rounding, the discard is a plain truncation, i.e. floor toward −∞.
- In-range test: bits Datos_Sum[2N-1:N+F-1] are all equal (all 0 or all 1).
  - In range: Datos_Trunc = slice and overflow = 0.
- Out of range:
  - If Datos_Sum[2N-1] = 0, Datos_Trunc = 2^(N-1)−1. For N=25 this is 25'h0FFFFFF.
  - If Datos_Sum[2N-1] = 1, Datos_Trunc = −2^(N-1). For N=25 this is 25'h1000000.
  - In both cases overflow = 1.
- All arithmetic is signed. Saturation is decided on the full-width value and never on a wrapped value.

## Timing
- Latency: 1 clock. Data sampled at edge k appears on Datos_Trunc, with out_valid = 1, after edge k.
- No backpressure. One input is accepted per cycle; back-to-back in_valid gives back-to-back results.
- in_valid low at an edge:
  - out_valid = 0 and overflow = 0.
  - Datos_Trunc holds its last value.
- Reset: rst_n low clears Datos_Trunc, out_valid and overflow to 0 immediately, independent of clk.
- Reset asserted mid-stream discards the in-flight result.
- After rst_n rises, the first edge with in_valid high produces the first result.

## Configuration
- Macro: TRUNCAMIENTO_ROUND_EN.
- Defined: round half up (toward +∞ at exact halves).
  - Add Datos_Sum[F-1] to Datos_Sum[2N-1:F].
  - Do the addition on a (2N−F+1)-bit sign-extended value, then apply the in-range test and saturation to the sum.
  - A rounding carry that leaves the range saturates and sets overflow.
- Not defined: pure truncation as described in Operation. Datos_Sum[F-1] is ignored.
- Latency and ports are identical in both builds.

## Test plan
All cases use N=25, F=10.
- Reset: hold rst_n=0 with random Datos_Sum and in_valid=1 → Datos_Trunc=0, out_valid=0, overflow=0, with no clock edge required.
- In-range positive: Datos_Sum=50'h0000000300000 (3.0) with in_valid=1 → next cycle Datos_Trunc=25'h0000C00, out_valid=1, overflow=0.
- In-range negative: Datos_Sum=−1572864 (−1.5) → Datos_Trunc=25'h1FFFA00, overflow=0. Then Datos_Sum=all ones (−2^-20) → 25'h1FFFFFF without the macro, 25'h0000000 with it.
- Saturation:
  - Datos_Sum=1<<40 → Datos_Trunc=25'h0FFFFFF, overflow=1.
  - Datos_Sum=−(1<<45) → 25'h1000000, overflow=1.
  - Datos_Sum=2^(2N-1)−1 → 25'h0FFFFFF with overflow=1 in both builds.
- Rounding boundary: Datos_Sum=50'h600 → 25'h0000001 without the macro, 25'h0000002 with it. Datos_Sum=50'h5FF → 25'h0000001 in both builds.
- Streaming: 5000 consecutive random inputs with in_valid=1 every cycle, then in_valid=0 → each output matches the reference model one cycle later. After in_valid drops, out_valid=0 and Datos_Trunc holds the last value.
